wb_periph_demux: RTL

Parametrised single-master to N-slave Wishbone peripheral fabric with registered slave strobes, registered response return, bus-error signalling and a per-transaction watchdog. Sits between `soc_picorv32_base` and the peripheral set (misc, UART, RGB, memctrl, memtest, LCD, SPI msg). Replaces the hand-built one-hot `wb_cyc` / flattened `wb_rdata` fan-out. Adds two capabilities the current fabric lacks: accesses to unmapped slots complete with an error, and hung peripherals time out.

---
 rtl/wb_bus_pkg.sv | 21 ++
 rtl/wb_watchdog.sv | 27 ++
 rtl/wb_periph_demux.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the Wishbone peripheral fabric.
// Holds the FSM state encoding, the default error data pattern and the slave-index width helper.
package wb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_GUARD
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // Watchdog counter width; large enough for the biggest legal TIMEOUT.
    localparam int WD_W = 16;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transaction cycle counter.
// expire is high once TIMEOUT-1 cycles have been counted since the last clear.
module wb_watchdog
    import wb_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WD_W'(1);
        end
    end

    assign expire = (cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_periph_demux.sv
// Single-master to N-slave Wishbone fabric with registered strobes and responses.
// Unmapped slots and hung slaves complete with m_err; errors are counted and their address kept.
module wb_periph_demux
    import wb_bus_pkg::*;
#(
    parameter int              N        = 7,
    parameter int              DW       = 32,
    parameter int              AW       = 16,
    parameter int              SEL_LSB  = 12,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = DW'(DEFAULT_ERR_DATA)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_wdata,
    input  logic [DW/8-1:0]     m_wmsk,
    input  logic                m_we,
    input  logic                m_cyc,
    output logic [DW-1:0]       m_rdata,
    output logic                m_ack,
    output logic                m_err,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    output logic [DW/8-1:0]     s_wmsk,
    output logic                s_we,
    output logic [N-1:0]        s_cyc,
    input  logic [N*DW-1:0]     s_rdata,
    input  logic [N-1:0]        s_ack,
    output logic [7:0]          err_cnt,
    output logic [AW-1:0]       err_addr
);

    localparam int IW = idx_width(N);

    state_t          state, next_state;
    logic [IW-1:0]   req_idx;
    logic            req_mapped;
    logic [N-1:0]    req_onehot;
    logic            accept, done_ok, done_err;
    logic            sel_ack;
    logic [DW-1:0]   sel_rdata;
    logic            expire;
    logic            err_q;

    assign req_idx    = m_addr[SEL_LSB +: IW];
    assign req_mapped = (int'(req_idx) < N);

    // s_cyc is one-hot on the selected slave, so masking with it both
    // picks the right ack and discards acks from every other slave.
    assign sel_ack = |(s_ack & s_cyc);

    always_comb begin
        req_onehot = '0;
        sel_rdata  = '0;
        for (int i = 0; i < N; i++) begin
            req_onehot[i] = req_mapped && (req_idx == IW'(i));
            if (s_cyc[i]) begin
                sel_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal is defaulted before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_cyc) begin
                    accept     = 1'b1;
                    next_state = req_mapped ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                // An ack in the last watchdog cycle still completes normally.
                if (sel_ack) begin
                    done_ok    = 1'b1;
                    next_state = ST_RESP;
                end else if (expire) begin
                    done_err   = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP:  next_state = ST_GUARD;
            ST_GUARD: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == ST_BUSY),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wmsk   <= '0;
            s_we     <= 1'b0;
            s_cyc    <= '0;
            err_q    <= 1'b0;
            m_rdata  <= '0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            if (accept) begin
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wmsk  <= m_wmsk;
                s_we    <= m_we;
                s_cyc   <= req_onehot;
                err_q   <= !req_mapped;
                if (!req_mapped) begin
                    m_rdata <= ERR_DATA;
                end
            end
            if (done_ok) begin
                s_cyc   <= '0;
                err_q   <= 1'b0;
                m_rdata <= sel_rdata;
            end
            if (done_err) begin
                s_cyc   <= '0;
                err_q   <= 1'b1;
                m_rdata <= ERR_DATA;
            end
            if (state == ST_RESP && err_q) begin
                err_addr <= s_addr;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    assign m_ack = (state == ST_RESP);
    assign m_err = m_ack && err_q;

endmodule
